// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: decodes the red/yellow/green lamp outputs of a traffic
// light controller back into a phase code. It measures each phase in millisecond
// ticks and raises sticky flags for illegal lamp patterns, illegal phase
// transitions and out-of-tolerance durations.
// Optional feature macro: TLMON_TIMECHK_EN compiles in the duration comparators.
// Without it err_time is tied to 0 and only the measurement remains.
module traffic_light_monitor #(
    parameter int RED_MS  = 96000,
    parameter int YEL_MS  = 4000,
    parameter int GRN_MS  = 20000,
    parameter int DARK_MS = 4000,
    parameter int TOL_MS  = 1,
    parameter int CW      = 17
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    input  logic          M,
    input  logic          K,
    input  logic          H,
    output logic [1:0]    phase,
    output logic [CW-1:0] dur,
    output logic          dur_valid,
    output logic          err_lamp,
    output logic          err_seq,
    output logic          err_time
);

    typedef enum logic [1:0] {
        PH_RED  = 2'b00,
        PH_YEL  = 2'b01,
        PH_GRN  = 2'b10,
        PH_DARK = 2'b11
    } phase_t;

    logic [2:0]    lamp_reg;
    phase_t        phase_reg, phase_next;
    logic          first_reg, first_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] dur_reg, dur_next;
    logic          dur_valid_reg, dur_valid_next;
    logic          err_lamp_reg, err_lamp_next;
    logic          err_seq_reg, err_seq_next;

    logic          dec_ok;
    phase_t        dec_phase;
    logic          change;
    logic          trans_ok;
    logic          time_bad;

    // Input stage: one register on the lamp lines; everything decodes from it.
    always_ff @(posedge clock) begin
        if (reset) lamp_reg <= 3'b000;
        else       lamp_reg <= {M, K, H};
    end

    // Decode lamps into a phase and classify the transition from the current one.
    always_comb begin
        dec_ok    = 1'b1;
        dec_phase = PH_DARK;
        case (lamp_reg)
            3'b100:  dec_phase = PH_RED;
            3'b010:  dec_phase = PH_YEL;
            3'b001:  dec_phase = PH_GRN;
            3'b000:  dec_phase = PH_DARK;
            default: dec_ok    = 1'b0;
        endcase
        change = dec_ok && (dec_phase != phase_reg);

        // Whitelist of allowed successors; anything else raises err_seq.
        trans_ok = 1'b0;
        case (phase_reg)
            PH_RED:  trans_ok = (dec_phase == PH_YEL);
            PH_YEL:  trans_ok = (dec_phase == PH_GRN) || (dec_phase == PH_DARK);
            PH_GRN:  trans_ok = (dec_phase == PH_RED) || (dec_phase == PH_YEL);
            PH_DARK: trans_ok = (dec_phase == PH_YEL) || (dec_phase == PH_RED);
            default: trans_ok = 1'b0;
        endcase
    end

`ifdef TLMON_TIMECHK_EN
    localparam int CW1 = CW + 1;

    logic [CW:0] nom_val, tol_val, lo_val, hi_val, cnt_ext;
    logic        err_time_reg, err_time_next;

    // Tolerance window of the outgoing phase; lower bound clamps at zero.
    always_comb begin
        case (phase_reg)
            PH_RED:  nom_val = CW1'(RED_MS);
            PH_YEL:  nom_val = CW1'(YEL_MS);
            PH_GRN:  nom_val = CW1'(GRN_MS);
            default: nom_val = CW1'(DARK_MS);
        endcase
        tol_val  = CW1'(TOL_MS);
        lo_val   = (nom_val > tol_val) ? (nom_val - tol_val) : '0;
        hi_val   = nom_val + tol_val;
        cnt_ext  = {1'b0, cnt_reg};
        time_bad = (cnt_ext < lo_val) || (cnt_ext > hi_val);
        err_time_next = err_time_reg;
        if (change && !first_reg && time_bad) err_time_next = 1'b1;
    end

    // Sticky duration error flag.
    always_ff @(posedge clock) begin
        if (reset) err_time_reg <= 1'b0;
        else       err_time_reg <= err_time_next;
    end

    assign err_time = err_time_reg;
`else
    assign time_bad = 1'b0;
    assign err_time = 1'b0;
`endif

    // Next state: counter, phase adoption, duration report and sticky flags.
    always_comb begin
        phase_next     = phase_reg;
        first_next     = first_reg;
        dur_next       = dur_reg;
        dur_valid_next = 1'b0;
        err_lamp_next  = err_lamp_reg | ~dec_ok;
        err_seq_next   = err_seq_reg;
        cnt_next       = (tick && (cnt_reg != '1)) ? (cnt_reg + 1'b1) : cnt_reg;

        if (change) begin
            phase_next = dec_phase;
            first_next = 1'b0;
            cnt_next   = tick ? CW'(1) : '0;
            // The start of the very first phase after reset is unknown, so it
            // is adopted without reporting or checking anything.
            if (!first_reg) begin
                dur_next       = cnt_reg;
                dur_valid_next = 1'b1;
                if (!trans_ok) err_seq_next = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_reg     <= PH_DARK;
            first_reg     <= 1'b1;
            cnt_reg       <= '0;
            dur_reg       <= '0;
            dur_valid_reg <= 1'b0;
            err_lamp_reg  <= 1'b0;
            err_seq_reg   <= 1'b0;
        end else begin
            phase_reg     <= phase_next;
            first_reg     <= first_next;
            cnt_reg       <= cnt_next;
            dur_reg       <= dur_next;
            dur_valid_reg <= dur_valid_next;
            err_lamp_reg  <= err_lamp_next;
            err_seq_reg   <= err_seq_next;
        end
    end

    assign phase     = phase_reg;
    assign dur       = dur_reg;
    assign dur_valid = dur_valid_reg;
    assign err_lamp  = err_lamp_reg;
    assign err_seq   = err_seq_reg;

endmodule
